// File: rtl/mdr_result_bcd_if.sv
// rtl/mdr_result_bcd_if.sv - operand/handshake and BCD readout bundle for mdr_result_bcd
interface mdr_result_bcd_if #(
    parameter int DW     = 16,
    parameter int DIGITS = 5
);
    logic [DW-1:0]         result;
    logic [DW-1:0]         remainder;
    logic                  ready;
    logic                  sel_rem;
    logic                  signed_mode;
    logic [4*DIGITS-1:0]   bcd;
    logic                  sign;
    logic                  valid;
    logic                  busy;
    logic                  overrun;

    // Arithmetic-unit side: drives operands, observes the formatted result.
    modport master (
        output result, remainder, ready, sel_rem, signed_mode,
        input  bcd, sign, valid, busy, overrun
    );

    // Formatter side.
    modport slave (
        input  result, remainder, ready, sel_rem, signed_mode,
        output bcd, sign, valid, busy, overrun
    );
endinterface

// File: rtl/mdr_result_bcd.sv
// rtl/mdr_result_bcd.sv - sequential double-dabble binary-to-BCD formatter (optional MDR_BCD_ZERO_BLANK_EN)
module mdr_result_bcd #(
    parameter int DW     = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    mdr_result_bcd_if.slave       bus
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [DW-1:0]   mag;
    logic [SW-1:0]   scratch;
    logic [CW-1:0]   iter;
    logic            sign_int;
    logic [SW-1:0]   bcd_q;
    logic            sign_q;
    logic            overrun_q;

    logic            accept;
    logic            drop;
    logic            last_iter;
    logic [DW-1:0]   operand;
    logic            operand_neg;
    logic [SW-1:0]   scratch_adj;
    logic [SW-1:0]   scratch_shift;
    logic [SW-1:0]   bcd_final;

    // Handshake decode: DONE accepts like IDLE so back-to-back operands lose no cycle.
    always_comb begin
        accept      = bus.ready && ((state == IDLE) || (state == DONE));
        drop        = bus.ready && (state == SHIFT);
        last_iter   = (state == SHIFT) && (iter == LAST_ITER);
        operand     = bus.sel_rem ? bus.remainder : bus.result;
        operand_neg = bus.signed_mode && operand[DW-1];
    end

    // One double-dabble step: add 3 to digits >= 5, then shift the next magnitude bit in.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_shift = {scratch_adj[SW-2:0], mag[DW-1]};
    end

`ifdef MDR_BCD_ZERO_BLANK_EN
    // Leading-zero blanking: digits above the top nonzero digit become 4'hF; digit 0 always shown.
    always_comb begin
        logic blank_on;
        bcd_final = scratch_shift;
        blank_on  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (scratch_shift[4*i +: 4] != 4'd0) begin
                blank_on = 1'b0;
            end
            if (blank_on) begin
                bcd_final[4*i +: 4] = 4'hF;
            end
        end
    end
`else
    // Leading zeros are presented as-is.
    always_comb begin
        bcd_final = scratch_shift;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? SHIFT : IDLE;
            SHIFT:   state_next = last_iter ? DONE : SHIFT;
            DONE:    state_next = accept ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag      <= '0;
            scratch  <= '0;
            iter     <= '0;
            sign_int <= 1'b0;
            bcd_q    <= '0;
            sign_q   <= 1'b0;
        end else if (accept) begin
            // Magnitude register is unsigned DW bits, so the most negative value still fits.
            mag      <= operand_neg ? (~operand + DW'(1)) : operand;
            sign_int <= operand_neg;
            scratch  <= '0;
            iter     <= '0;
        end else if (state == SHIFT) begin
            scratch <= scratch_shift;
            mag     <= {mag[DW-2:0], 1'b0};
            iter    <= last_iter ? '0 : iter + CW'(1);
            if (last_iter) begin
                bcd_q  <= bcd_final;
                sign_q <= sign_int;
            end
        end
    end

    // Sticky overrun: set by a ready dropped while busy, cleared by the next accepted ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (accept) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.bcd     = bcd_q;
    assign bus.sign    = sign_q;
    assign bus.valid   = (state == DONE);
    assign bus.busy    = (state == SHIFT);
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_mdr_result_bcd.sv
// tb/tb_mdr_result_bcd.sv - scoreboard testbench for mdr_result_bcd
module tb_mdr_result_bcd;

    typedef struct {
        logic [19:0] bcd;
        logic        sign;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    exp_t sb[$];

    mdr_result_bcd_if #(.DW(16), .DIGITS(5)) bus ();

    mdr_result_bcd #(.DW(16), .DIGITS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits by plain arithmetic, sign by two's-complement range.
    function automatic logic [20:0] model(input logic [15:0] res, input logic [15:0] rem,
                                          input logic sr, input logic sm);
        int          op;
        int          v;
        int          top;
        logic        s;
        logic [19:0] b;
        op  = sr ? int'(rem) : int'(res);
        s   = sm && (op >= 32768);
        v   = s ? (65536 - op) : op;
        top = 0;
        b   = '0;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            if ((v % 10) != 0) top = i;
            v = v / 10;
        end
`ifdef MDR_BCD_ZERO_BLANK_EN
        for (int i = top + 1; i < 5; i++) b[4*i +: 4] = 4'hF;
`endif
        return {s, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] res, input logic [15:0] rem,
                        input logic sr, input logic sm, input logic push);
        logic [20:0] m;
        bus.result      = res;
        bus.remainder   = rem;
        bus.sel_rem     = sr;
        bus.signed_mode = sm;
        bus.ready       = 1'b1;
        if (push) begin
            m = model(res, rem, sr, sm);
            sb.push_back('{bcd: m[19:0], sign: m[20], due: cyc + 17});
        end
        tick();
        bus.ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
        check("drain", sb.size(), 0);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (!rst && bus.valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd", 32'(bus.bcd), 32'(e.bcd));
                check("sign", 32'(bus.sign), 32'(e.sign));
                check("latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        int cnt;
        logic [15:0] v;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst   = 1'b1;
        bus.result      = '0;
        bus.remainder   = '0;
        bus.ready       = 1'b0;
        bus.sel_rem     = 1'b0;
        bus.signed_mode = 1'b0;
        repeat (3) tick();
        check("rst_bcd", 32'(bus.bcd), 32'h0);
        check("rst_sign", 32'(bus.sign), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'h0);
        rst = 1'b0;
        tick();

        // Basic conversion with busy-length measurement.
        send(16'd12345, 16'd0, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) cnt++;
            tick();
        end
        check("busy_cycles", 32'(cnt), 32'd16);
        drain();

        // Directed values, each next operand landing in the DONE cycle (back-to-back).
        send(16'hFFF6, 16'd0, 1'b0, 1'b1, 1'b1);
        repeat (16) tick();
        send(16'hFFF6, 16'd0, 1'b0, 1'b0, 1'b1);
        check("b2b_overrun", 32'(bus.overrun), 32'h0);
        check("b2b_busy", 32'(bus.busy), 32'h1);
        repeat (16) tick();
        send(16'h8000, 16'd0, 1'b0, 1'b1, 1'b1);
        repeat (16) tick();
        send(16'hFFFF, 16'd0, 1'b0, 1'b0, 1'b1);
        repeat (16) tick();
        send(16'h0000, 16'd0, 1'b0, 1'b1, 1'b1);
        repeat (16) tick();
        send(16'd42, 16'd0, 1'b0, 1'b0, 1'b1);
        repeat (16) tick();
        send(16'd999, 16'd7, 1'b1, 1'b0, 1'b1);
        drain();

        // Dropped ready while busy.
        send(16'd31337, 16'd0, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        send(16'd1111, 16'd0, 1'b0, 1'b0, 1'b0);
        check("overrun_set", 32'(bus.overrun), 32'h1);
        repeat (5) tick();
        check("overrun_sticky", 32'(bus.overrun), 32'h1);
        drain();
        check("overrun_hold_idle", 32'(bus.overrun), 32'h1);
        send(16'd500, 16'd0, 1'b0, 1'b0, 1'b1);
        check("overrun_clear", 32'(bus.overrun), 32'h0);
        drain();

        // Reset mid-conversion aborts without a valid.
        send(16'd4321, 16'd0, 1'b0, 1'b0, 1'b0);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_bcd", 32'(bus.bcd), 32'h0);
        check("abort_valid", 32'(bus.valid), 32'h0);
        repeat (25) tick();
        send(16'd9876, 16'd0, 1'b0, 1'b0, 1'b1);
        drain();

        // Randomized operands and spacing.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0:       v = 16'h8000;
                1:       v = 16'hFFFF;
                2:       v = 16'(($urandom_range(0, 9)));
                default: v = 16'($urandom);
            endcase
            send(v, 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            repeat ($urandom_range(16, 20)) tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
